// File: rtl/spi_master_adapter.sv
// Adapts val/rdy payload streams to a framed SPI mode-0 master link with
// one-entry TX and RX buffers, write-accept retries and read-only polling.
module spi_master_adapter #(
    parameter int nbits   = 34,
    parameter int clk_div = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             recv_val,
    input  logic [nbits-3:0] recv_msg,
    output logic             recv_rdy,
    output logic             send_val,
    output logic [nbits-3:0] send_msg,
    input  logic             send_rdy,
    input  logic             poll_en,
    output logic             sclk,
    output logic             cs,
    output logic             mosi,
    input  logic             miso
);
    localparam int PW = nbits - 2;
    localparam int HW = $clog2(2 * nbits);
    localparam logic [7:0]    DIV_LAST  = 8'(clk_div - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * nbits - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    state_e           state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic [HW-1:0]    half_q, half_d;
    logic [nbits-2:0] tx_tail_q, tx_tail_d;
    logic [nbits-1:0] rx_sr_q, rx_sr_d;
    logic             wr_val_q, wr_val_d;
    logic             rd_rdy_q, rd_rdy_d;
    logic             tx_full_q, tx_full_d;
    logic [PW-1:0]    tx_buf_q, tx_buf_d;
    logic             rx_full_q, rx_full_d;
    logic [PW-1:0]    rx_buf_q, rx_buf_d;
    logic             recv_rdy_q, recv_rdy_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;

    logic div_done, frame_go, start, half_end, sclk_rise, sclk_fall, frame_done;

    assign div_done   = (div_q == DIV_LAST);
    assign frame_go   = tx_full_q || (poll_en && !rx_full_q);
    assign start      = (state_q == IDLE) && frame_go;
    assign half_end   = (state_q == SHIFT) && div_done;
    assign sclk_rise  = half_end && !half_q[0];
    assign sclk_fall  = half_end && half_q[0];
    assign frame_done = (state_q == HOLD) && div_done;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_go) state_d = SETUP;
            SETUP:   if (div_done) state_d = SHIFT;
            SHIFT:   if (div_done && half_q == HALF_LAST) state_d = HOLD;
            HOLD:    if (div_done) state_d = GAP;
            GAP:     if (div_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SPI pins are registered; cs follows the state being entered so the
    // low window is exactly SETUP + SHIFT + HOLD.
    always_comb begin
        cs_d   = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        if (sclk_rise) sclk_d = 1'b1;
        if (sclk_fall) sclk_d = 1'b0;
        if (start)     mosi_d = tx_full_q;
        if (sclk_fall) mosi_d = tx_tail_q[nbits-2];
    end

    always_comb begin
        div_d      = (state_q == IDLE || div_done) ? 8'd0 : div_q + 8'd1;
        half_d     = '0;
        tx_tail_d  = tx_tail_q;
        rx_sr_d    = rx_sr_q;
        wr_val_d   = wr_val_q;
        rd_rdy_d   = rd_rdy_q;
        tx_full_d  = tx_full_q;
        tx_buf_d   = tx_buf_q;
        rx_full_d  = rx_full_q;
        rx_buf_d   = rx_buf_q;
        if (state_q == SHIFT) half_d = div_done ? half_q + HW'(1) : half_q;
        // Header bits reflect buffer state at frame start and stay frozen.
        if (start) begin
            wr_val_d  = tx_full_q;
            rd_rdy_d  = !rx_full_q;
            tx_tail_d = {!rx_full_q, tx_full_q ? tx_buf_q : PW'(0)};
        end
        if (sclk_fall) tx_tail_d = {tx_tail_q[nbits-3:0], 1'b0};
        if (sclk_rise) rx_sr_d   = {rx_sr_q[nbits-2:0], miso};
        if (frame_done) begin
            if (wr_val_q && rx_sr_q[nbits-2]) tx_full_d = 1'b0;
            if (rd_rdy_q && rx_sr_q[nbits-1]) begin
                rx_full_d = 1'b1;
                rx_buf_d  = rx_sr_q[PW-1:0];
            end
        end
        if (rx_full_q && send_rdy) rx_full_d = 1'b0;
        if (recv_val && recv_rdy_q) begin
            tx_full_d = 1'b1;
            tx_buf_d  = recv_msg;
        end
        recv_rdy_d = !tx_full_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q      <= '0;
            half_q     <= '0;
            tx_tail_q  <= '0;
            rx_sr_q    <= '0;
            wr_val_q   <= 1'b0;
            rd_rdy_q   <= 1'b0;
            tx_full_q  <= 1'b0;
            tx_buf_q   <= '0;
            rx_full_q  <= 1'b0;
            rx_buf_q   <= '0;
            recv_rdy_q <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            half_q     <= half_d;
            tx_tail_q  <= tx_tail_d;
            rx_sr_q    <= rx_sr_d;
            wr_val_q   <= wr_val_d;
            rd_rdy_q   <= rd_rdy_d;
            tx_full_q  <= tx_full_d;
            tx_buf_q   <= tx_buf_d;
            rx_full_q  <= rx_full_d;
            rx_buf_q   <= rx_buf_d;
            recv_rdy_q <= recv_rdy_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign recv_rdy = recv_rdy_q;
    assign send_val = rx_full_q;
    assign send_msg = rx_buf_q;
    assign cs       = cs_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
endmodule

// File: tb/tb_spi_master_adapter.sv
// Self-checking bench: a minion model answers each frame, a monitor records
// frames, and a transaction-level buffer model predicts every header and payload.
module tb_spi_master_adapter;
    localparam int NB  = 34;
    localparam int DIV = 2;

    logic        clk, reset;
    logic        recv_val, recv_rdy, send_val, send_rdy, poll_en;
    logic [31:0] recv_msg, send_msg;
    logic        sclk, cs, mosi, miso;

    spi_master_adapter #(.nbits(NB), .clk_div(DIV)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_msg(recv_msg), .recv_rdy(recv_rdy),
        .send_val(send_val), .send_msg(send_msg), .send_rdy(send_rdy),
        .poll_en(poll_en), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [NB-1:0] mosi;
        int            rises;
        int            cslow;
        logic [NB-1:0] rsp;
    } frame_t;

    typedef struct {
        logic          load;
        logic          poll;
        logic [31:0]   pay;
        logic [NB-1:0] rsp;
        logic [NB-1:0] want_mosi;
        logic          want_sv;
        logic [31:0]   want_msg;
        logic          want_rr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor / minion state
    logic [NB-1:0] rsp_q[$];
    frame_t        frame_q[$];
    logic [NB-1:0] rsp_cur = '0;
    logic [NB-1:0] mon_mosi = '0;
    int            mon_rises = 0, mon_cslow = 0, hi_cnt = 0, gap_min = 1000;
    int            bidx = 0, frame_cnt = 0;
    logic          cs_prev = 1'b1, sclk_prev = 1'b0, started = 1'b0;
    frame_t        last_fr;

    always @(negedge clk) begin
        frame_t fr;
        if (cs_prev && !cs) begin
            if (rsp_q.size() > 0) rsp_cur = rsp_q.pop_front();
            else rsp_cur = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7), 32'($urandom)};
            if (started && hi_cnt < gap_min) gap_min = hi_cnt;
            bidx = NB - 1; mon_mosi = '0; mon_rises = 0; mon_cslow = 0;
        end
        if (!cs_prev && cs) begin
            fr.mosi = mon_mosi; fr.rises = mon_rises; fr.cslow = mon_cslow; fr.rsp = rsp_cur;
            frame_q.push_back(fr);
            last_fr = fr;
            frame_cnt++;
            hi_cnt = 0;
        end
        if (cs) hi_cnt++; else mon_cslow++;
        if (!sclk_prev && sclk) begin
            mon_mosi = {mon_mosi[NB-2:0], mosi};
            mon_rises++;
        end
        if (sclk_prev && !sclk && !cs && bidx > 0) bidx--;
        miso = rsp_cur[bidx];
        cs_prev = cs; sclk_prev = sclk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic do_recv(input logic [31:0] d);
        int t = 0;
        while (!recv_rdy && t < 1000) begin tick(); t++; end
        chk("recv_rdy_wait", recv_rdy, 1);
        recv_val = 1'b1; recv_msg = d;
        @(posedge clk); tick();
        recv_val = 1'b0;
    endtask

    task automatic do_send();
        send_rdy = 1'b1;
        @(posedge clk); tick();
        send_rdy = 1'b0;
    endtask

    task automatic wait_frame(input string nm);
        int f0 = frame_cnt;
        int t = 0;
        while (frame_cnt == f0 && t < 3000) begin tick(); t++; end
        chk(nm, (frame_cnt != f0), 1);
    endtask

    task automatic settle();
        int quiet = 0;
        int t = 0;
        while (quiet < 8 && t < 5000) begin
            tick(); t++;
            if (cs && recv_rdy) quiet++; else quiet = 0;
        end
        chk("settle_timeout", (quiet >= 8), 1);
    endtask

    // transaction-level buffer model
    logic        m_tx_full = 1'b0, m_rx_full = 1'b0;
    logic [31:0] m_tx = '0, m_rx = '0;

    task automatic process_frames();
        frame_t        fr;
        logic [NB-1:0] want;
        while (frame_q.size() > 0) begin
            fr   = frame_q.pop_front();
            want = {m_tx_full, !m_rx_full, m_tx_full ? m_tx : 32'h0};
            chk("rand_mosi_frame", fr.mosi, want);
            chk("rand_rises", fr.rises, NB);
            chk("rand_cs_low", fr.cslow, (2 * NB + 2) * DIV);
            if (m_tx_full && fr.rsp[NB-2]) m_tx_full = 1'b0;
            if (!m_rx_full && fr.rsp[NB-1]) begin
                m_rx_full = 1'b1;
                m_rx      = fr.rsp[31:0];
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        int f0, lowcnt, t;
        reset = 1'b0; recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b0; poll_en = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 34'h100000000, 34'h3DEADBEEF, 1'b0, 32'h0,        1'b1};
        vecs[1] = '{1'b0, 1'b1, 32'h0,        34'h212345678, 34'h100000000, 1'b1, 32'h12345678, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h00000001, 34'h100000000, 34'h300000001, 1'b0, 32'h0,        1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFFFFFF, 34'h3CAFEF00D, 34'h3FFFFFFFF, 1'b1, 32'hCAFEF00D, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h0,        34'h10000ABCD, 34'h100000000, 1'b0, 32'h0,        1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h80000000, 34'h300000000, 34'h380000000, 1'b1, 32'h00000000, 1'b1};

        // reset held 3 cycles, then released
        repeat (3) @(posedge clk);
        tick();
        chk("in_reset_cs", cs, 1);
        chk("in_reset_sclk", sclk, 0);
        chk("in_reset_recv_rdy", recv_rdy, 0);
        chk("in_reset_send_val", send_val, 0);
        reset = 1'b1;
        @(posedge clk); tick();
        chk("post_reset_cs", cs, 1);
        chk("post_reset_sclk", sclk, 0);
        chk("post_reset_mosi", mosi, 0);
        chk("post_reset_send_val", send_val, 0);
        chk("post_reset_recv_rdy", recv_rdy, 1);
        started = 1'b1;

        // table of single-frame transactions from empty buffers
        for (int i = 0; i < 6; i++) begin
            rsp_q.push_back(vecs[i].rsp);
            if (vecs[i].load) do_recv(vecs[i].pay);
            if (vecs[i].poll) poll_en = 1'b1;
            wait_frame($sformatf("vec%0d_frame_timeout", i));
            poll_en = 1'b0;
            chk($sformatf("vec%0d_mosi", i), last_fr.mosi, vecs[i].want_mosi);
            chk($sformatf("vec%0d_rises", i), last_fr.rises, NB);
            chk($sformatf("vec%0d_cs_low", i), last_fr.cslow, (2 * NB + 2) * DIV);
            chk($sformatf("vec%0d_send_val", i), send_val, vecs[i].want_sv);
            chk($sformatf("vec%0d_recv_rdy", i), recv_rdy, vecs[i].want_rr);
            if (vecs[i].want_sv) begin
                chk($sformatf("vec%0d_send_msg", i), send_msg, vecs[i].want_msg);
                do_send();
                chk($sformatf("vec%0d_drained", i), send_val, 0);
            end
            repeat (4) tick();
        end

        // write refused twice, accepted on the third frame
        rsp_q.push_back(34'h000000000);
        rsp_q.push_back(34'h000000000);
        rsp_q.push_back(34'h100000000);
        do_recv(32'hA5A5A5A5);
        for (int k = 0; k < 3; k++) begin
            wait_frame($sformatf("retry%0d_timeout", k));
            chk($sformatf("retry%0d_mosi", k), last_fr.mosi, 34'h3A5A5A5A5);
            chk($sformatf("retry%0d_cs_low", k), last_fr.cslow, (2 * NB + 2) * DIV);
            chk($sformatf("retry%0d_recv_rdy", k), recv_rdy, (k == 2));
        end
        settle();

        // RX full blocks polling; a write frame then drops the response
        rsp_q.push_back(34'h200000055);
        poll_en = 1'b1;
        wait_frame("fill_rx_timeout");
        chk("fill_rx_send_val", send_val, 1);
        f0 = frame_cnt;
        repeat (300) tick();
        chk("no_poll_when_rx_full", frame_cnt - f0, 0);
        poll_en = 1'b0;
        rsp_q.push_back(34'h300000999);
        do_recv(32'h00000001);
        wait_frame("rd_rdy0_timeout");
        chk("rd_rdy0_mosi", last_fr.mosi, 34'h200000001);
        chk("rd_rdy0_send_msg", send_msg, 32'h55);
        chk("rd_rdy0_send_val", send_val, 1);
        chk("rd_rdy0_recv_rdy", recv_rdy, 1);
        do_send();
        chk("rd_rdy0_drained", send_val, 0);

        // randomized traffic against the buffer model
        settle();
        frame_q.delete();
        m_tx_full = 1'b0; m_rx_full = 1'b0;
        for (int it = 0; it < 40; it++) begin
            logic [31:0] d;
            settle();
            process_frames();
            chk("rand_recv_rdy", recv_rdy, !m_tx_full);
            chk("rand_send_val", send_val, m_rx_full);
            case ($urandom_range(0, 2))
                0: begin
                    d = $urandom;
                    do_recv(d);
                    m_tx = d; m_tx_full = 1'b1;
                end
                1: if (m_rx_full) begin
                    chk("rand_send_msg", send_msg, m_rx);
                    do_send();
                    m_rx_full = 1'b0;
                end
                default: begin
                    poll_en = 1'b1;
                    repeat ($urandom_range(100, 600)) tick();
                    poll_en = 1'b0;
                end
            endcase
        end
        settle();
        process_frames();

        // reset at the 20th sclk rise aborts the frame and empties buffers
        rsp_q.push_back(34'h300000000);
        do_recv(32'h13579BDF);
        t = 0;
        while (cs && t < 100) begin tick(); t++; end
        while (mon_rises < 20 && t < 2000) begin tick(); t++; end
        chk("abort_reach_rise20", mon_rises, 20);
        reset = 1'b0;
        @(posedge clk); tick();
        chk("abort_cs", cs, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_mosi", mosi, 0);
        chk("abort_send_val", send_val, 0);
        chk("abort_recv_rdy", recv_rdy, 0);
        reset = 1'b1;
        @(posedge clk); tick();
        chk("abort_release_recv_rdy", recv_rdy, 1);
        chk("abort_release_send_val", send_val, 0);
        lowcnt = 0;
        repeat (300) begin tick(); lowcnt += !cs; end
        chk("abort_no_new_frame", lowcnt, 0);
        chk("cs_high_gap_min", (gap_min >= DIV), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master_adapter.md
SPI_MASTER_ADAPTER -- requirements
Module: spi_master_adapter

Interface
REQ-001 SHALL have parameter nbits, default 34; SPI frame width in bits, so the payload is nbits-2 bits.
REQ-002 SHALL have parameter clk_div, default 2; SCLK half-period in clk cycles, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, and all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; synchronous, active-low (0 = reset).
REQ-005 SHALL have port recv_val / recv_msg / recv_rdy, in / in[nbits-2] / out; the payload to transmit, on a val/rdy handshake.
REQ-006 SHALL have port send_val / send_msg / send_rdy, out / out[nbits-2] / in; the payload received, on a val/rdy handshake.
REQ-007 SHALL have port poll_en, input, 1 bit; enables read-only polling frames.
REQ-008 SHALL have port sclk, cs, mosi, each an output of 1 bit; SPI mode 0, cs active-low.
REQ-009 SHALL have port miso, input, 1 bit; SPI data returned by the minion.

Function
REQ-010 SHALL send the MOSI frame MSB first: bit[nbits-1] = wr_val (TX buffer full at frame start); bit[nbits-2] = rd_rdy (RX buffer empty at frame start); bits[nbits-3:0] = TX payload, or 0 when wr_val=0.
REQ-011 SHALL interpret the MISO frame as: bit[nbits-1] = rsp_val; bit[nbits-2] = minion_spc (the minion accepted the write); bits[nbits-3:0] = response payload.
REQ-012 SHALL have a one-entry TX buffer, with recv_rdy = !tx_full; a recv handshake loads the buffer on the same edge.
REQ-013 SHALL have a one-entry RX buffer, with send_val = rx_full and send_msg = the buffer contents; a send handshake clears it.
REQ-014 SHALL use FSM states IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-015 SHALL leave IDLE for SETUP when tx_full || (poll_en && !rx_full); the wr_val/rd_rdy bits are latched and the shift register loaded on that edge.
REQ-016 SHALL hold cs=0 in SETUP, SHIFT and HOLD, and cs=1 in IDLE and GAP; all SPI outputs SHALL be registered.
REQ-017 SHALL spend clk_div cycles in each of SETUP, HOLD and GAP, then GAP -> IDLE.
REQ-018 SHALL run SHIFT for 2*nbits half-periods of clk_div cycles each: sclk rises at the end of even half-periods and falls at the end of odd ones.
REQ-019 SHALL place the MSB on mosi when SETUP is entered; mosi updates only on sclk falling edges.
REQ-020 SHALL sample miso on the clk edge that raises sclk.
REQ-021 SHALL keep sclk at 0 outside SHIFT and at the end of SHIFT, with exactly nbits rising edges per frame.
REQ-022 SHALL hold cs low for exactly (2*nbits+2)*clk_div cycles per frame, and hold it high for at least clk_div cycles between frames.
REQ-023 SHALL apply the following updates on HOLD -> GAP.
  - wr_val=1 and minion_spc=1: clear tx_full (write accepted).
  - wr_val=1 and minion_spc=0: keep tx_full and the payload, and retransmit the same payload in the next frame.
  - rd_rdy=1 and rsp_val=1: load the RX buffer and set rx_full.
  - rd_rdy=0: ignore rsp_val.
REQ-024 SHALL allow recv and send handshakes in any state; changes after frame start do not alter the bits already latched for that frame.
REQ-025 SHALL start no frame when tx is empty and poll_en=0, or when tx is empty and rx is full.

Reset
REQ-026 SHALL, while reset=0, force on the next edge: state=IDLE, cs=1, sclk=0, mosi=0, tx_full=0, rx_full=0, recv_rdy=0, send_val=0, bit counter=0, divider=0.
REQ-027 SHALL, on reset asserted mid-frame, abort the frame (cs high next edge, no partial update) and discard both buffers.
REQ-028 SHALL drive recv_rdy=1 in the first cycle after reset is released.

Verification (nbits=34, clk_div=2)
REQ-029 Scenario: reset held for 3 cycles, then released -> cs=1, sclk=0, mosi=0, send_val=0, recv_rdy=1.
REQ-030 Scenario: recv 0xDEADBEEF, minion returns spc=1, rsp_val=0 -> mosi frame = 2'b11 followed by 0xDEADBEEF; cs low 140 cycles; 34 sclk rises; recv_rdy=1 after GAP.
REQ-031 Scenario: poll_en=1, tx empty, minion returns rsp_val=1 with payload 0x12345678 -> mosi = 2'b01 followed by zeros; send_val=1 with send_msg=0x12345678 after HOLD; no new frame while send_rdy=0.
REQ-032 Scenario: recv 0xA5A5A5A5, minion returns spc=0 twice, then spc=1 -> three identical frames; recv_rdy stays 0 until the third frame ends.
REQ-033 Scenario: RX full, send_rdy=0, then recv 0x1 -> the frame carries rd_rdy=0; a rsp_val=1 returned by the minion is dropped and the RX buffer is unchanged.
REQ-034 Scenario: reset asserted at the 20th sclk rise -> cs=1 and sclk=0 on the next edge; buffers empty; no send_val.
